// File: rtl/gf256_inv_sequencer_pkg.sv
// gf256_inv_sequencer_pkg: shared types and constants for the masked GF(2^8) inverse sequencer
package gf256_inv_sequencer_pkg;
    localparam int NBYTES = 16;
    localparam int INV_LATENCY = 4;
    localparam int STATE_W = 8 * NBYTES;
    localparam int LANE_W = 4;
    localparam logic [31:0] LFSR_SEED = 32'hACE12468;
    // x^32+x^22+x^2+x+1 as a right-shifting Galois toggle mask
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    typedef logic [LANE_W-1:0] lane_t;
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} seqState_t;
endpackage

// File: rtl/gf256_inv_sequencer_if.sv
// gf256_inv_sequencer_if: byte-side link between the sequencer and the masked inverse unit
interface gf256_inv_sequencer_if;
    logic [7:0] inv_in_sh0;
    logic [7:0] inv_in_sh1;
    logic [7:0] inv_guards;
    logic [3:0] inv_random;
    logic [7:0] inv_out_sh0;
    logic [7:0] inv_out_sh1;
    modport master (
        output inv_in_sh0, inv_in_sh1, inv_guards, inv_random,
        input  inv_out_sh0, inv_out_sh1
    );
    modport slave (
        input  inv_in_sh0, inv_in_sh1, inv_guards, inv_random,
        output inv_out_sh0, inv_out_sh1
    );
endinterface

// File: rtl/prng_lfsr12.sv
// prng_lfsr12: 32-bit Galois LFSR advancing 12 positions per enabled cycle, exposing the bits shifted out
module prng_lfsr12 #(
    parameter logic [31:0] SEED = 32'hACE12468,
    parameter logic [31:0] TAPS = 32'h80200003
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        load,
    input  logic [31:0] loadVal,
    input  logic        en,
    output logic [11:0] bits
);
    logic [31:0] lfsr;
    logic [31:0] lfsrNext;

    // bits[0] is the first bit shifted out this cycle
    always_comb begin
        lfsrNext = lfsr;
        bits = '0;
        for (int k = 0; k < 12; k++) begin
            bits[k] = lfsrNext[0];
            lfsrNext = (lfsrNext >> 1) ^ (lfsrNext[0] ? TAPS : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) lfsr <= SEED;
        else if (load) lfsr <= (loadVal == 32'h0) ? SEED : loadVal;
        else if (en) lfsr <= lfsrNext;
    end
endmodule

// File: rtl/gf256_inv_sequencer.sv
// gf256_inv_sequencer: streams a 2-share 128-bit state through the masked GF(2^8) inverse unit and reassembles the result
module gf256_inv_sequencer
    import gf256_inv_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 start,
    input  logic [STATE_W-1:0]   state_sh0,
    input  logic [STATE_W-1:0]   state_sh1,
    input  logic [31:0]          seed,
    input  logic                 seed_load,
    output logic                 busy,
    output logic                 done,
    output logic [STATE_W-1:0]   result_sh0,
    output logic [STATE_W-1:0]   result_sh1,
    gf256_inv_sequencer_if.master inv
);
    seqState_t state;
    seqState_t stateNext;
    lane_t feedCnt;
    lane_t capCnt;
    logic capEn;
    logic go;
    logic seedLoad;
    logic lastFeed;
    logic latHit;
    logic lastCap;
    logic loadFeed;
    logic shiftFeed;
    logic [11:0] prngBits;
    logic [STATE_W-9:0] feedSh0;
    logic [STATE_W-9:0] feedSh1;
    logic [STATE_W-9:0] capSh0;
    logic [STATE_W-9:0] capSh1;

    assign go = start && !seed_load;
    assign lastFeed = feedCnt == lane_t'(NBYTES - 1);
    assign latHit = feedCnt == lane_t'(INV_LATENCY - 1);
    assign lastCap = capCnt == lane_t'(NBYTES - 1);
    assign loadFeed = state == IDLE && go;
    assign shiftFeed = state == FEED && !lastFeed;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = (state == IDLE)  ? (go ? FEED : IDLE) :
                    (state == FEED)  ? (lastFeed ? DRAIN : FEED) :
                    (state == DRAIN) ? (latHit ? DONE : DRAIN) :
                                       IDLE;
    end

    always_comb begin
        busy = state == FEED || state == DRAIN;
        done = state == DONE;
        seedLoad = state == IDLE && seed_load;
        inv.inv_guards = busy ? prngBits[7:0] : 8'h0;
        inv.inv_random = busy ? prngBits[11:8] : 4'h0;
    end

    // one counter serves FEED (byte index) and DRAIN (latency countdown)
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) feedCnt <= '0;
        else feedCnt <= (busy && stateNext == state) ? feedCnt + lane_t'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            feedSh0 <= '0;
            inv.inv_in_sh0 <= '0;
        end else if (loadFeed) begin
            feedSh0 <= state_sh0[STATE_W-1:8];
            inv.inv_in_sh0 <= state_sh0[7:0];
        end else if (shiftFeed) begin
            feedSh0 <= {8'h0, feedSh0[STATE_W-9:8]};
            inv.inv_in_sh0 <= feedSh0[7:0];
        end else begin
            inv.inv_in_sh0 <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            feedSh1 <= '0;
            inv.inv_in_sh1 <= '0;
        end else if (loadFeed) begin
            feedSh1 <= state_sh1[STATE_W-1:8];
            inv.inv_in_sh1 <= state_sh1[7:0];
        end else if (shiftFeed) begin
            feedSh1 <= {8'h0, feedSh1[STATE_W-9:8]};
            inv.inv_in_sh1 <= feedSh1[7:0];
        end else begin
            inv.inv_in_sh1 <= '0;
        end
    end

    // capture window opens INV_LATENCY cycles after the first byte went out
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            capEn <= 1'b0;
            capCnt <= '0;
        end else begin
            if (state == FEED && latHit) capEn <= 1'b1;
            else if (capEn && lastCap) capEn <= 1'b0;
            capCnt <= capEn ? capCnt + lane_t'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            capSh0 <= '0;
            result_sh0 <= '0;
        end else if (capEn) begin
            capSh0 <= {inv.inv_out_sh0, capSh0[STATE_W-9:8]};
            if (lastCap) result_sh0 <= {inv.inv_out_sh0, capSh0};
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            capSh1 <= '0;
            result_sh1 <= '0;
        end else if (capEn) begin
            capSh1 <= {inv.inv_out_sh1, capSh1[STATE_W-9:8]};
            if (lastCap) result_sh1 <= {inv.inv_out_sh1, capSh1};
        end
    end

    prng_lfsr12 #(
        .SEED(LFSR_SEED),
        .TAPS(LFSR_TAPS)
    ) prng (
        .clk(clk),
        .rst_i(rst_i),
        .load(seedLoad),
        .loadVal(seed),
        .en(busy),
        .bits(prngBits)
    );
endmodule

// File: tb/tb_gf256_inv_sequencer.sv
// tb_gf256_inv_sequencer: table-driven passes through a delay/xor stub inverse unit with a result scoreboard and PRNG model
module tb_gf256_inv_sequencer;
    import gf256_inv_sequencer_pkg::*;

    typedef struct {
        logic [127:0] sh0;
        logic [127:0] sh1;
        logic [127:0] exp0;
        logic [127:0] exp1;
    } vec_t;

    typedef struct {
        logic [127:0] exp0;
        logic [127:0] exp1;
    } res_t;

    localparam logic [127:0] MASK5A = {16{8'h5A}};

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start = 1'b0;
    logic seed_load = 1'b0;
    logic [127:0] state_sh0 = '0;
    logic [127:0] state_sh1 = '0;
    logic [31:0] seed = '0;
    logic busy;
    logic done;
    logic [127:0] result_sh0;
    logic [127:0] result_sh1;
    logic [7:0] pipe0 [INV_LATENCY];
    logic [7:0] pipe1 [INV_LATENCY];
    vec_t vecs [4];
    res_t sbQ [$];
    logic [31:0] mLfsr;
    int checks = 0;
    int errors = 0;

    gf256_inv_sequencer_if invBus ();

    gf256_inv_sequencer dut (
        .clk(clk),
        .rst_i(rst_i),
        .start(start),
        .state_sh0(state_sh0),
        .state_sh1(state_sh1),
        .seed(seed),
        .seed_load(seed_load),
        .busy(busy),
        .done(done),
        .result_sh0(result_sh0),
        .result_sh1(result_sh1),
        .inv(invBus)
    );

    always #5 clk = ~clk;

    // stub inverse unit: INV_LATENCY delay per share, share 0 xored with 5A
    always_ff @(posedge clk) begin
        pipe0[0] <= invBus.inv_in_sh0;
        pipe1[0] <= invBus.inv_in_sh1;
        for (int k = 1; k < INV_LATENCY; k++) begin
            pipe0[k] <= pipe0[k-1];
            pipe1[k] <= pipe1[k-1];
        end
    end
    assign invBus.inv_out_sh0 = pipe0[INV_LATENCY-1] ^ 8'h5A;
    assign invBus.inv_out_sh1 = pipe1[INV_LATENCY-1];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic mStep(output logic [11:0] w);
        logic fb;
        for (int k = 0; k < 12; k++) begin
            fb = mLfsr[0];
            w[k] = fb;
            mLfsr = {1'b0, mLfsr[31:1]};
            if (fb) mLfsr = mLfsr ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
        end
    endtask

    task automatic runPass(input logic [127:0] s0, input logic [127:0] s1,
                           input logic [127:0] e0, input logic [127:0] e1, input bit extra);
        res_t r;
        res_t got;
        logic [11:0] w;
        logic [11:0] words [$];
        logic [7:0] b0;
        logic [7:0] b1;
        int dups;
        dups = 0;
        r.exp0 = e0;
        r.exp1 = e1;
        @(negedge clk);
        state_sh0 = s0;
        state_sh1 = s1;
        start = 1'b1;
        sbQ.push_back(r);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            start = extra && (n == 5 || n == 20 || n == 21);
            state_sh0 = {$urandom, $urandom, $urandom, $urandom};
            state_sh1 = {$urandom, $urandom, $urandom, $urandom};
            b0 = 8'h0;
            b1 = 8'h0;
            if (n <= 16) begin
                b0 = s0[8*(n-1) +: 8];
                b1 = s1[8*(n-1) +: 8];
            end
            chk($sformatf("busy@%0d", n), busy, n <= 20);
            chk($sformatf("done@%0d", n), done, n == 21);
            chk($sformatf("in_sh0@%0d", n), invBus.inv_in_sh0, b0);
            chk($sformatf("in_sh1@%0d", n), invBus.inv_in_sh1, b1);
            w = 12'h0;
            if (n <= 20) begin
                mStep(w);
                words.push_back(w);
            end
            chk($sformatf("prng@%0d", n), {invBus.inv_random, invBus.inv_guards}, w);
            if (done) begin
                if (sbQ.size() == 0) begin
                    chk("sb_underflow", sbQ.size(), 1);
                end else begin
                    got = sbQ.pop_front();
                    chk("res_sh0", result_sh0, got.exp0);
                    chk("res_sh1", result_sh1, got.exp1);
                end
            end
        end
        chk("res_hold_sh0", result_sh0, e0);
        chk("res_hold_sh1", result_sh1, e1);
        for (int i = 0; i < words.size(); i++)
            for (int j = i + 1; j < words.size(); j++)
                if (words[i] == words[j]) dups++;
        chk("prng_unique", dups, 0);
    endtask

    initial begin
        vecs[0].sh0 = 128'h0F0E0D0C0B0A09080706050403020100;
        vecs[0].sh1 = '0;
        vecs[1].sh0 = {$urandom, $urandom, $urandom, $urandom};
        vecs[1].sh1 = {$urandom, $urandom, $urandom, $urandom};
        vecs[2].sh0 = '1;
        vecs[2].sh1 = MASK5A;
        vecs[3].sh0 = MASK5A;
        vecs[3].sh1 = 128'h80000000000000000000000000000001;
        for (int i = 0; i < 4; i++) begin
            vecs[i].exp0 = vecs[i].sh0 ^ MASK5A;
            vecs[i].exp1 = vecs[i].sh1;
        end

        #2 rst_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res_sh0", result_sh0, 0);
        chk("rst_res_sh1", result_sh1, 0);
        chk("rst_in_sh0", invBus.inv_in_sh0, 0);
        chk("rst_prng", {invBus.inv_random, invBus.inv_guards}, 0);
        rst_i = 1'b1;
        mLfsr = LFSR_SEED;

        for (int i = 0; i < 4; i++) begin
            runPass(vecs[i].sh0, vecs[i].sh1, vecs[i].exp0, vecs[i].exp1, 1'b0);
            chk($sformatf("xor_%0d", i), result_sh0 ^ result_sh1, (vecs[i].sh0 ^ vecs[i].sh1) ^ MASK5A);
        end

        // start pulses while busy and in DONE must not disturb or restart the pass
        runPass(vecs[1].sh1, vecs[1].sh0, vecs[1].sh1 ^ MASK5A, vecs[1].sh0, 1'b1);

        // zero seed falls back to the reset seed, then a seed of 1
        @(negedge clk);
        seed = 32'h0;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        mLfsr = LFSR_SEED;
        runPass(vecs[0].sh0, vecs[0].sh1, vecs[0].exp0, vecs[0].exp1, 1'b0);
        @(negedge clk);
        seed = 32'h1;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        mLfsr = 32'h1;
        runPass(vecs[2].sh0, vecs[2].sh1, vecs[2].exp0, vecs[2].exp1, 1'b0);

        // seed_load together with start: seed taken, no pass begins
        @(negedge clk);
        seed = 32'h12345678;
        seed_load = 1'b1;
        start = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        start = 1'b0;
        mLfsr = 32'h12345678;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("sl_busy@%0d", n), busy, 0);
            chk($sformatf("sl_prng@%0d", n), {invBus.inv_random, invBus.inv_guards}, 0);
            @(negedge clk);
        end
        runPass(vecs[1].sh0, vecs[1].sh1, vecs[1].exp0, vecs[1].exp1, 1'b0);

        // asynchronous reset in cycle 10 of a pass
        @(negedge clk);
        state_sh0 = vecs[3].sh0;
        state_sh1 = vecs[3].sh1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_res_sh0", result_sh0, 0);
        chk("mid_rst_res_sh1", result_sh1, 0);
        chk("mid_rst_in_sh0", invBus.inv_in_sh0, 0);
        @(negedge clk);
        rst_i = 1'b1;
        mLfsr = LFSR_SEED;
        runPass(vecs[3].sh0, vecs[3].sh1, vecs[3].exp0, vecs[3].exp1, 1'b0);

        chk("sb_drained", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gf256_inv_sequencer.md
Name: gf256_inv_sequencer

Overview:
- Controller for the masked pipelined GF(2^8) inverse unit.
- Accepts a 2-share 128-bit state, streams its 16 bytes into the inverse unit one per cycle, and supplies fresh guards/random from an internal PRNG.
- Collects the 16 shared output bytes and reassembles them into a 2-share 128-bit result with a done pulse.
- Sits between the round controller (state side) and the inverse unit (byte side).

Parameters:
- INV_LATENCY, 4: cycles from byte presented on inv_in_* to its result on inv_out_*.
- NBYTES, 16: bytes per state.
- LFSR_SEED, 32'hACE12468: PRNG reset value, also substituted for an all-zero seed.

Ports:
- clk, input, 1: clock, all flops rising edge.
- rst_i, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a pass; honoured only in IDLE.
- state_sh0, input, 128: share 0 of input state; byte i = bits [8i+7:8i].
- state_sh1, input, 128: share 1 of input state.
- seed, input, 32: PRNG seed value.
- seed_load, input, 1: load seed; honoured only in IDLE.
- busy, output, 1: high in FEED or DRAIN.
- done, output, 1: one-cycle pulse when result_* is valid.
- result_sh0, output, 128: share 0 of output state; held until next done.
- result_sh1, output, 128: share 1 of output state.
- inv_in_sh0, output, 8: byte share 0 to inverse unit.
- inv_in_sh1, output, 8: byte share 1 to inverse unit.
- inv_guards, output, 8: fresh guard bits to inverse unit.
- inv_random, output, 4: fresh random bits to inverse unit.
- inv_out_sh0, input, 8: byte share 0 from inverse unit.
- inv_out_sh1, input, 8: byte share 1 from inverse unit.

Behaviour:
Reset (rst_i low, asynchronous):
- FSM goes to IDLE; all counters and result_* are 0; busy and done are 0.
- inv_in_* are 0; LFSR is set to LFSR_SEED.

FSM states:
- IDLE:
  - inv_in_*, inv_guards and inv_random are driven 0; LFSR holds.
  - seed_load: LFSR <= seed, or LFSR_SEED if seed == 0. start is ignored in the same cycle.
  - start (without seed_load): latch both state shares into input shift registers, then go to FEED.
- FEED, 16 cycles:
  - Feed counter f runs 0..15; byte f of each share is driven on inv_in_sh0/sh1 (registered outputs).
  - After f = 15, go to DRAIN.
- DRAIN, INV_LATENCY cycles:
  - inv_in_* driven 0.
  - After the last cycle, go to DONE.
- DONE, 1 cycle:
  - done = 1, then return to IDLE.

Timing and capture:
- If start is sampled at edge 0, byte i is on inv_in_* during cycle 1+i.
- Its result is sampled from inv_out_* at the end of cycle 1+i+INV_LATENCY.
- A capture counter c runs independently of f. It is enabled from cycle 1+INV_LATENCY for 16 cycles.
- Captured byte c is written to result byte c of each share; shares are never combined.
- done is high in cycle 17+INV_LATENCY (cycle 21 by default). result_* update atomically no later than that cycle.

PRNG:
- 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
- Advances 12 positions per cycle in FEED and DRAIN only; holds in IDLE and DONE.
- The 12 bits shifted out form {inv_random, inv_guards}: inv_guards = bits [7:0], inv_random = bits [11:8].
- No output bit is ever reused across cycles.
- random is consumed later in the inverse pipeline than guards, so fresh values must continue through DRAIN.

Boundary conditions:
- start while busy: ignored, with no effect on the current pass.
- start in the DONE cycle: ignored.
- start and seed_load together in IDLE: seed_load wins and start is dropped.
- Reset mid-pass: abort immediately. No done; result_* read 0.
- state_sh* may change after start is sampled without affecting the pass.

Security rules:
- Share 0 and share 1 of the same byte never pass through a common combinational node inside this block.
- Separate shift registers per share.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, FEED, DRAIN, DONE.
  - Constants NBYTES, INV_LATENCY, LFSR_SEED, LFSR taps.
  - Byte-lane index width, 4 bits.
- One sub-module: prng_lfsr12, a 32-bit LFSR with load, enable and 12-bit/cycle output, reused by other masked units.

Test Plan:
Benches use a stub inverse unit that delays each share by INV_LATENCY and applies x -> x^8'h5A to share 0 only.
1. Reset, then state_sh0 = 128'h0F0E..0100, sh1 = 0, start at cycle 0 -> bytes 00..0F appear on inv_in_sh0 in cycles 1..16; done at cycle 21; result_sh0 byte i = i^5A; result_sh1 = 0.
2. sh0 = random R, sh1 = random M -> result_sh0 ^ result_sh1 == (R^M) with each byte ^5A; both shares equal the stub outputs.
3. start pulsed at cycles 5 and 20 of a pass -> single done at cycle 21; second start not honoured; busy low only in IDLE/DONE.
4. seed_load = 1 with seed = 0, then seed = 32'h1 on a new run -> first case reproduces the LFSR_SEED sequence. Guard and random streams are bit-exact vs. a reference model; no 12-bit word repeats within a pass.
5. rst_i low at cycle 10 of a pass -> busy, done and result_* are 0 immediately; the next start runs cleanly to done.
6. seed_load and start together in IDLE -> seed loaded, busy stays 0, no pass started.
